// File: rtl/selector.sv
// Shared decode/commit selector types and CP0 constants.
// Used by the exception unit and its CP0 register file.
package selector;

    typedef enum logic [1:0] {
        NONE,
        SYSCALL,
        RESERVERD,
        OVERFLOW
    } exc_chk_t;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        REDIRECT
    } exc_state_t;

    localparam logic [4:0] EXCCODE_SYS = 5'd8;
    localparam logic [4:0] EXCCODE_RI  = 5'd10;
    localparam logic [4:0] EXCCODE_OV  = 5'd12;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // Only the software interrupt bits of Cause are writable by MTC0
    localparam logic [31:0] CAUSE_WMASK = 32'h0000_0300;

    function automatic logic [4:0] exc_code(input exc_chk_t k);
        logic [4:0] c;
        c = 5'd0;
        case (k)
            SYSCALL:   c = EXCCODE_SYS;
            RESERVERD: c = EXCCODE_RI;
            OVERFLOW:  c = EXCCODE_OV;
            default:   c = 5'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cp0_regfile.sv
// CP0 Status/Cause/EPC storage with write masking.
// Exception and ERET updates take precedence over MTC0.
module cp0_regfile
    import selector::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    input  logic        exc_take,
    input  logic [4:0]  exc_code_in,
    input  logic [31:0] exc_epc,
    input  logic        exc_bd,
    input  logic        eret_take,
    output logic [31:0] rdata,
    output logic [31:0] epc
);

    logic [31:0] status;
    logic [31:0] cause;

    // Register update: exception entry, ERET, then software write
    always_ff @(posedge clk) begin
        if (reset) begin
            status <= 32'd0;
            cause  <= 32'd0;
            epc    <= 32'd0;
        end else if (exc_take) begin
            status[1]    <= 1'b1;
            cause[6:2]   <= exc_code_in;
            // Nested exception keeps the original return point
            if (!status[1]) begin
                epc       <= exc_epc;
                cause[31] <= exc_bd;
            end
        end else if (eret_take) begin
            status[1] <= 1'b0;
        end else if (we) begin
            case (addr)
                CP0_STATUS: status <= wdata;
                CP0_CAUSE:  cause  <= (cause & ~CAUSE_WMASK)
                                    | (wdata & CAUSE_WMASK);
                CP0_EPC:    epc    <= wdata;
                default:    ;
            endcase
        end
    end

    // MFC0 read port, no bypass of a same-cycle write
    always_comb begin
        rdata = 32'd0;
        case (addr)
            CP0_STATUS: rdata = status;
            CP0_CAUSE:  rdata = cause;
            CP0_EPC:    rdata = epc;
            default:    rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/exception_unit.sv
// Commit-stage exception/ERET sequencer.
// Flushes younger stages, then issues a one-cycle fetch redirect.
module exception_unit
    import selector::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        commit_in_delay,
    input  exc_chk_t    commit_exc,
    input  logic        commit_overflow,
    input  logic        commit_eret,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    exc_state_t  state;
    exc_state_t  state_nx;
    logic [3:0]  cnt;
    logic [31:0] target;
    logic [31:0] epc;
    logic        idle;
    logic        hit;
    logic        trigger;
    logic        eret_take;
    logic        we_ok;
    logic [31:0] epc_new;

    assign idle = (state == IDLE);

    // Decide whether the committing instruction raises an exception
    always_comb begin
        hit = 1'b0;
        case (commit_exc)
            SYSCALL:   hit = 1'b1;
            RESERVERD: hit = 1'b1;
            OVERFLOW:  hit = commit_overflow;
            default:   hit = 1'b0;
        endcase
    end

    assign trigger   = idle && commit_valid && hit;
    assign eret_take = idle && commit_valid && commit_eret && !trigger;
    assign we_ok     = cp0_we && idle && !trigger && !eret_take;
    assign epc_new   = commit_in_delay ? commit_pc - 32'd4 : commit_pc;

    cp0_regfile u_cp0 (
        .clk         (clk),
        .reset       (reset),
        .we          (we_ok),
        .addr        (cp0_addr),
        .wdata       (cp0_wdata),
        .exc_take    (trigger),
        .exc_code_in (exc_code(commit_exc)),
        .exc_epc     (epc_new),
        .exc_bd      (commit_in_delay),
        .eret_take   (eret_take),
        .rdata       (cp0_rdata),
        .epc         (epc)
    );

    // State, flush counter and redirect target registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            target <= 32'd0;
        end else begin
            state <= state_nx;
            if (trigger || eret_take) begin
                cnt    <= CNT_INIT;
                target <= trigger ? EXC_VECTOR : epc;
            end else if (state == FLUSH && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Next-state selection
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (trigger || eret_take) state_nx = FLUSH;
            FLUSH:    if (cnt == 4'd0) state_nx = REDIRECT;
            REDIRECT: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Pipeline control outputs decoded from state
    always_comb begin
        flush    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        unique case (state)
            IDLE:     ;
            FLUSH:    begin flush = 1'b1; stall = 1'b1; end
            REDIRECT: begin flush = 1'b1; redirect = 1'b1; end
            default:  ;
        endcase
    end

    assign redirect_pc = target;

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit.
// Hand-computed expected CP0 contents and redirect timing.
module tb_exception_unit;
    import selector::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_in_delay;
    exc_chk_t    commit_exc;
    logic        commit_overflow;
    logic        commit_eret;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    exception_unit dut (
        .clk             (clk),
        .reset           (reset),
        .commit_valid    (commit_valid),
        .commit_pc       (commit_pc),
        .commit_in_delay (commit_in_delay),
        .commit_exc      (commit_exc),
        .commit_overflow (commit_overflow),
        .commit_eret     (commit_eret),
        .cp0_we          (cp0_we),
        .cp0_addr        (cp0_addr),
        .cp0_wdata       (cp0_wdata),
        .cp0_rdata       (cp0_rdata),
        .flush           (flush),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        commit_valid    = 1'b0;
        commit_pc       = 32'd0;
        commit_in_delay = 1'b0;
        commit_exc      = NONE;
        commit_overflow = 1'b0;
        commit_eret     = 1'b0;
        cp0_we          = 1'b0;
        cp0_wdata       = 32'd0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a,
                      input logic [31:0] exp);
        cp0_addr = a;
        #1;
        chk(tag, cp0_rdata, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cp0_we    = 1'b1;
        cp0_addr  = a;
        cp0_wdata = d;
        step();
        cp0_we    = 1'b0;
    endtask

    task automatic commit(input exc_chk_t k, input logic [31:0] pc,
                          input logic dly, input logic ov,
                          input logic er);
        commit_valid    = 1'b1;
        commit_exc      = k;
        commit_pc       = pc;
        commit_in_delay = dly;
        commit_overflow = ov;
        commit_eret     = er;
    endtask

    // Called one step after the triggering edge (cycle N+1)
    task automatic seq(input string tag, input logic [31:0] tgt);
        chk({tag, "_f1"}, {30'd0, flush, stall}, 32'd3);
        chk({tag, "_r1"}, {31'd0, redirect}, 32'd0);
        step();
        chk({tag, "_f2"}, {30'd0, flush, stall}, 32'd3);
        chk({tag, "_r2"}, {31'd0, redirect}, 32'd0);
        step();
        chk({tag, "_rd"}, {29'd0, redirect, flush, stall}, 32'd6);
        chk({tag, "_pc"}, redirect_pc, tgt);
        step();
        chk({tag, "_idle"}, {29'd0, redirect, flush, stall}, 32'd0);
    endtask

    initial begin
        clr();
        cp0_addr = 5'd0;
        reset    = 1'b1;
        step();
        step();
        chk("rst_ctl", {29'd0, redirect, flush, stall}, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        rd("rst_status", CP0_STATUS, 32'd0);
        rd("rst_cause", CP0_CAUSE, 32'd0);
        rd("rst_epc", CP0_EPC, 32'd0);
        reset = 1'b0;

        // SYSCALL, not in delay slot; junk during flush is ignored
        commit(SYSCALL, 32'h0040_0010, 1'b0, 1'b0, 1'b0);
        step();
        commit(SYSCALL, 32'h0000_0999, 1'b0, 1'b0, 1'b0);
        cp0_we    = 1'b1;
        cp0_addr  = CP0_EPC;
        cp0_wdata = 32'h0000_1234;
        seq("sys", 32'h8000_0180);
        clr();
        rd("sys_epc", CP0_EPC, 32'h0040_0010);
        rd("sys_cause", CP0_CAUSE, 32'h0000_0020);
        rd("sys_status", CP0_STATUS, 32'h0000_0002);

        // Software writes: Status, masked Cause, unmapped address
        wr(CP0_STATUS, 32'd0);
        rd("wr_status", CP0_STATUS, 32'd0);
        wr(CP0_CAUSE, 32'hFFFF_FFFF);
        rd("wr_cause", CP0_CAUSE, 32'h0000_0320);
        wr(5'd5, 32'h1234_5678);
        rd("wr_other", 5'd5, 32'd0);

        // Reserved instruction in delay slot
        commit(RESERVERD, 32'h0040_0024, 1'b1, 1'b0, 1'b0);
        step();
        clr();
        seq("ri", 32'h8000_0180);
        rd("ri_epc", CP0_EPC, 32'h0040_0020);
        rd("ri_cause", CP0_CAUSE, 32'h8000_0328);

        // OVERFLOW qualified by the ALU flag
        wr(CP0_STATUS, 32'd0);
        commit(OVERFLOW, 32'h0040_0030, 1'b0, 1'b0, 1'b0);
        step();
        clr();
        chk("ov0_ctl", {29'd0, redirect, flush, stall}, 32'd0);
        commit(OVERFLOW, 32'h0040_0030, 1'b0, 1'b1, 1'b0);
        step();
        clr();
        seq("ov1", 32'h8000_0180);
        rd("ov_cause", CP0_CAUSE, 32'h0000_0330);
        rd("ov_status", CP0_STATUS, 32'h0000_0002);
        rd("ov_epc", CP0_EPC, 32'h0040_0030);

        // ERET returns to EPC and clears EXL
        wr(CP0_EPC, 32'h0040_0014);
        commit(NONE, 32'h0040_0100, 1'b0, 1'b0, 1'b1);
        step();
        clr();
        seq("eret", 32'h0040_0014);
        rd("eret_status", CP0_STATUS, 32'd0);

        // Same-cycle MTC0 is dropped by the exception
        commit(SYSCALL, 32'h0040_0040, 1'b0, 1'b0, 1'b0);
        cp0_we    = 1'b1;
        cp0_addr  = CP0_EPC;
        cp0_wdata = 32'hDEAD_BEEF;
        step();
        clr();
        seq("syswe", 32'h8000_0180);
        rd("syswe_epc", CP0_EPC, 32'h0040_0040);
        rd("syswe_status", CP0_STATUS, 32'h0000_0002);

        // Nested trigger with EXL=1, plus ERET losing priority
        commit(SYSCALL, 32'h0040_0050, 1'b1, 1'b0, 1'b1);
        step();
        clr();
        seq("nest", 32'h8000_0180);
        rd("nest_epc", CP0_EPC, 32'h0040_0040);
        rd("nest_cause", CP0_CAUSE, 32'h0000_0320);
        rd("nest_status", CP0_STATUS, 32'h0000_0002);

        // Reset during second flush cycle aborts the redirect
        commit(SYSCALL, 32'h0040_0060, 1'b0, 1'b0, 1'b0);
        step();
        clr();
        chk("abort_f1", {30'd0, flush, stall}, 32'd3);
        step();
        chk("abort_f2", {30'd0, flush, stall}, 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_ctl", {29'd0, redirect, flush, stall}, 32'd0);
        chk("abort_rpc", redirect_pc, 32'd0);
        rd("abort_status", CP0_STATUS, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort_noredir", {31'd0, redirect}, 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h8000_0180, exception handler entry address.
REQ-002 Parameter FLUSH_CYCLES, default 2, number of cycles flush is held before redirect; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 commit_valid  input  1  commit-stage instruction present.
REQ-006 commit_pc  input  32  PC of committing instruction.
REQ-007 commit_in_delay  input  1  committing instruction sits in a branch delay slot.
REQ-008 commit_exc  input  selector::exc_chk_t  exception check kind from decode: NONE, SYSCALL, RESERVERD, OVERFLOW.
REQ-009 commit_overflow  input  1  ALU overflow flag; qualifies OVERFLOW only.
REQ-010 commit_eret  input  1  committing instruction is ERET.
REQ-011 cp0_we  input  1  CP0 write enable (MTC0).
REQ-012 cp0_addr  input  5  CP0 register number.
REQ-013 cp0_wdata  input  32  CP0 write data.
REQ-014 cp0_rdata  output  32  CP0 read data (MFC0), combinational from addr.
REQ-015 flush  output  1  kill all younger pipeline stages.
REQ-016 stall  output  1  unit busy; commit inputs ignored.
REQ-017 redirect  output  1  one-cycle fetch redirect strobe.
REQ-018 redirect_pc  output  32  redirect target; valid only when redirect=1.

Function
REQ-019 Trigger: commit_valid=1 and in IDLE and (commit_exc=SYSCALL, or RESERVERD, or OVERFLOW with commit_overflow=1); commit_exc=NONE never triggers.
REQ-020 ExcCode written to Cause[6:2]: SYSCALL=8, RESERVERD=10, OVERFLOW=12.
REQ-021 On trigger with Status.EXL(bit1)=0: EPC <= commit_in_delay ? commit_pc-4 : commit_pc (mod 2^32); Cause.BD(bit31) <= commit_in_delay.
REQ-022 On trigger with Status.EXL=1: EPC and Cause.BD unchanged; ExcCode still updated.
REQ-023 On trigger: Status.EXL <= 1; target latched = EXC_VECTOR.
REQ-024 ERET: commit_valid=1, commit_eret=1, no trigger, IDLE -> Status.EXL <= 0; target latched = EPC value before this edge.
REQ-025 Trigger takes priority over ERET in the same cycle.
REQ-026 FSM states IDLE, FLUSH, REDIRECT.
REQ-027 IDLE -> FLUSH on trigger or ERET; counter loaded with FLUSH_CYCLES-1.
REQ-028 FLUSH: flush=1, stall=1; counter decrements each cycle; at 0 -> REDIRECT.
REQ-029 REDIRECT: redirect=1, redirect_pc=latched target, flush=1, stall=0; next state IDLE unconditionally.
REQ-030 Latency: trigger/ERET at edge N -> redirect=1 in cycle N+FLUSH_CYCLES+1 for exactly one cycle.
REQ-031 IDLE outputs: flush=0, stall=0, redirect=0.
REQ-032 Commit inputs and cp0_we ignored outside IDLE.
REQ-033 CP0 registers: Status(12) all bits writable; Cause(13) only bits [9:8] writable; EPC(14) all bits writable; other addresses read 0, writes dropped.
REQ-034 cp0_we in same cycle as trigger/ERET: write dropped entirely.
REQ-035 cp0_rdata reflects register contents before the current edge (no write bypass).

Reset
REQ-036 reset=1 at a clock edge: state IDLE, counter 0, Status=0, Cause=0, EPC=0, latched target=0; outputs flush=0, stall=0, redirect=0, redirect_pc=0 from the next cycle.
REQ-037 Reset in FLUSH or REDIRECT aborts the sequence; no redirect issued afterwards.

Structure
REQ-038 ExcCode constants, CP0 register numbers, and FSM state enum SHALL live in the shared signals/selector package beside exc_chk_t.
REQ-039 CP0 register storage and write masking SHALL be a sub-module cp0_regfile; FSM and counter stay in exception_unit.

Verification
REQ-040 SYSCALL at pc 32'h0040_0010, not in delay slot, EXL=0 -> EPC=32'h0040_0010, Cause[6:2]=8, BD=0, EXL=1, flush cycles N+1..N+3, redirect=1 with pc 32'h8000_0180 in cycle N+3.
REQ-041 RESERVERD at pc 32'h0040_0024 in delay slot -> EPC=32'h0040_0020, BD=1, ExcCode=10.
REQ-042 OVERFLOW with commit_overflow=0 -> no flush; with commit_overflow=1 -> ExcCode=12, EXL=1.
REQ-043 EPC=32'h0040_0014, EXL=1, ERET -> EXL=0, redirect_pc=32'h0040_0014 after 2 flush cycles.
REQ-044 SYSCALL and cp0_we (addr 14, data 32'hDEAD_BEEF) in same cycle -> EPC holds the SYSCALL pc; trigger while EXL=1 leaves EPC unchanged.
REQ-045 reset asserted during the second FLUSH cycle -> next cycle flush=0, stall=0, and no redirect ever issued.
